// File: rtl/deadtime_monitor_pkg.sv
// deadtime_monitor_pkg: shared widths, polarity type and state encodings for the dead-time monitor
package deadtime_monitor_pkg;
  localparam int DTCOUNT_WIDTH_DEF = 10;
  typedef logic _logic_pwm;
  typedef enum logic [1:0] {S_BOTH_OFF, S_A_ON, S_B_ON, S_FAULT} _state_dtmon;
  typedef enum logic [1:0] {LAST_NONE, LAST_A, LAST_B} _last_leg;
endpackage

// File: rtl/deadtime_monitor.sv
// deadtime_monitor: measures A->B / B->A dead time, flags short gaps, latches shoot-through and drives kill
//   inputs : clk, reset (async, high), en, gate_A/gate_B (pin level), logic_A/logic_B (1 = inverted),
//            dtime_min (minimum gap), fault_clear (level)
//   outputs: dt_ab/dt_ba (last gaps), dt_ab_valid/dt_ba_valid (update pulses), dt_viol (short-gap pulse),
//            viol_sticky, shoot_fault (in fault state), kill (registered copy of shoot_fault)
module deadtime_monitor
  import deadtime_monitor_pkg::*;
#(
  parameter int DTCOUNT_WIDTH = DTCOUNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     gate_A,
  input  logic                     gate_B,
  input  _logic_pwm                logic_A,
  input  _logic_pwm                logic_B,
  input  logic [DTCOUNT_WIDTH-1:0] dtime_min,
  input  logic                     fault_clear,
  output logic [DTCOUNT_WIDTH-1:0] dt_ab,
  output logic [DTCOUNT_WIDTH-1:0] dt_ba,
  output logic                     dt_ab_valid,
  output logic                     dt_ba_valid,
  output logic                     dt_viol,
  output logic                     viol_sticky,
  output logic                     shoot_fault,
  output logic                     kill
);
  _state_dtmon state, state_n;
  _last_leg last_leg, last_n;
  logic [DTCOUNT_WIDTH-1:0] gap_cnt, gap_n, dt_ab_n, dt_ba_n, meas;
  logic a, b, ab_v, ba_v, viol, clr, sticky_n;
  always_comb begin
    a = gate_A ^ logic_A;
    b = gate_B ^ logic_B;
    state_n = state;
    last_n = last_leg;
    gap_n = gap_cnt;
    dt_ab_n = dt_ab;
    dt_ba_n = dt_ba;
    ab_v = 1'b0;
    ba_v = 1'b0;
    if (a && b && state != S_FAULT)
      state_n = S_FAULT;
    else
      case (state)
        S_BOTH_OFF:
          if (a) begin
            state_n = S_A_ON;
            if (last_leg == LAST_B) begin
              dt_ba_n = gap_cnt;
              ba_v = 1'b1;
            end
          end else if (b) begin
            state_n = S_B_ON;
            if (last_leg == LAST_A) begin
              dt_ab_n = gap_cnt;
              ab_v = 1'b1;
            end
          end else
            gap_n = &gap_cnt ? gap_cnt : gap_cnt + 1'b1;
        S_A_ON:
          if (!a && !b) begin
            state_n = S_BOTH_OFF;
            gap_n = DTCOUNT_WIDTH'(1);
            last_n = LAST_A;
          end else if (!a) begin
            state_n = S_B_ON;
            dt_ab_n = '0;
            ab_v = 1'b1;
          end
        S_B_ON:
          if (!a && !b) begin
            state_n = S_BOTH_OFF;
            gap_n = DTCOUNT_WIDTH'(1);
            last_n = LAST_B;
          end else if (!b) begin
            state_n = S_A_ON;
            dt_ba_n = '0;
            ba_v = 1'b1;
          end
        S_FAULT:
          if (fault_clear && !a && !b) begin
            state_n = S_BOTH_OFF;
            last_n = LAST_NONE;
            gap_n = '0;
          end
        default: state_n = S_BOTH_OFF;
      endcase
    meas = ab_v ? dt_ab_n : dt_ba_n;
    viol = (ab_v || ba_v) && meas < dtime_min;
    // inside the fault state, fault_clear only counts when it actually releases the fault
    clr = fault_clear && (state != S_FAULT || (!a && !b));
    sticky_n = viol || (viol_sticky && !clr);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_BOTH_OFF;
      last_leg <= LAST_NONE;
      gap_cnt <= '0;
      dt_ab <= '0;
      dt_ba <= '0;
      dt_ab_valid <= 1'b0;
      dt_ba_valid <= 1'b0;
      dt_viol <= 1'b0;
      viol_sticky <= 1'b0;
      kill <= 1'b0;
    end else if (!en) begin
      state <= S_BOTH_OFF;
      last_leg <= LAST_NONE;
      gap_cnt <= '0;
      dt_ab_valid <= 1'b0;
      dt_ba_valid <= 1'b0;
      dt_viol <= 1'b0;
      viol_sticky <= 1'b0;
      kill <= 1'b0;
    end else begin
      state <= state_n;
      last_leg <= last_n;
      gap_cnt <= gap_n;
      dt_ab <= dt_ab_n;
      dt_ba <= dt_ba_n;
      dt_ab_valid <= ab_v;
      dt_ba_valid <= ba_v;
      dt_viol <= viol;
      viol_sticky <= sticky_n;
      kill <= state_n == S_FAULT;
    end
  assign shoot_fault = state == S_FAULT;
endmodule

// File: tb/tb_deadtime_monitor.sv
// tb_deadtime_monitor: directed and random stimulus against a timestamp-based reference model
module tb_deadtime_monitor;
  localparam int W = 4;
  localparam int MAXG = (1 << W) - 1;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0;
  logic gate_A = 1'b0, gate_B = 1'b0, logic_A = 1'b0, logic_B = 1'b0, fault_clear = 1'b0;
  logic [W-1:0] dtime_min = '0;
  logic [W-1:0] dt_ab, dt_ba;
  logic dt_ab_valid, dt_ba_valid, dt_viol, viol_sticky, shoot_fault, kill;
  int checks = 0, errors = 0;
  int t = 0, off_t = 0, off_leg = 0;
  int m_ab = 0, m_ba = 0;
  bit pa, pb, m_fault, m_sticky, m_abv, m_bav, m_viol;
  always #5 clk = ~clk;
  deadtime_monitor #(.DTCOUNT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .gate_A(gate_A), .gate_B(gate_B),
    .logic_A(logic_A), .logic_B(logic_B), .dtime_min(dtime_min), .fault_clear(fault_clear),
    .dt_ab(dt_ab), .dt_ba(dt_ba), .dt_ab_valid(dt_ab_valid), .dt_ba_valid(dt_ba_valid),
    .dt_viol(dt_viol), .viol_sticky(viol_sticky), .shoot_fault(shoot_fault), .kill(kill)
  );
  function automatic int sat(int g);
    return g > MAXG ? MAXG : g;
  endfunction
  task automatic model_reset();
    pa = 0; pb = 0; m_fault = 0; m_sticky = 0; m_abv = 0; m_bav = 0; m_viol = 0;
    off_leg = 0; m_ab = 0; m_ba = 0;
  endtask
  // off_leg/off_t remember which leg went off and when; a gap is the elapsed sample count
  task automatic model(bit a, bit b, bit fc, bit e, int dmin);
    m_abv = 0; m_bav = 0; m_viol = 0;
    if (!e) begin
      m_fault = 0; off_leg = 0; pa = 0; pb = 0; m_sticky = 0;
    end else if (m_fault) begin
      if (fc && !a && !b) begin
        m_fault = 0; off_leg = 0; pa = 0; pb = 0; m_sticky = 0;
      end
    end else if (a && b) begin
      m_fault = 1;
      if (fc) m_sticky = 0;
    end else begin
      if (a && !pa && (pb || off_leg == 2)) begin
        m_ba = pb ? 0 : sat(t - off_t);
        m_bav = 1;
      end
      if (b && !pb && (pa || off_leg == 1)) begin
        m_ab = pa ? 0 : sat(t - off_t);
        m_abv = 1;
      end
      if (!a && !b && (pa || pb)) begin
        off_leg = pa ? 1 : 2;
        off_t = t;
      end
      m_viol = (m_abv && m_ab < dmin) || (m_bav && m_ba < dmin);
      m_sticky = m_viol || (m_sticky && !fc);
      pa = a; pb = b;
    end
    t++;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("dt_ab", 32'(dt_ab), m_ab);
    chk("dt_ba", 32'(dt_ba), m_ba);
    chk("dt_ab_valid", 32'(dt_ab_valid), 32'(m_abv));
    chk("dt_ba_valid", 32'(dt_ba_valid), 32'(m_bav));
    chk("dt_viol", 32'(dt_viol), 32'(m_viol));
    chk("viol_sticky", 32'(viol_sticky), 32'(m_sticky));
    chk("shoot_fault", 32'(shoot_fault), 32'(m_fault));
    chk("kill", 32'(kill), 32'(m_fault));
  endtask
  task automatic tick(bit a, bit b, bit fc);
    gate_A = a ^ logic_A;
    gate_B = b ^ logic_B;
    fault_clear = fc;
    @(posedge clk);
    model(a, b, fc, en, int'(dtime_min));
    #1 check_all();
  endtask
  initial begin
    int lv, r;
    lv = 0;
    dtime_min = 4'd5;
    #1 reset = 1'b1;
    #1 model_reset();
    check_all();
    #10 reset = 1'b0;
    en = 1'b1;
    repeat (10) tick(1, 0, 0);
    repeat (7) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("ab_gap7", 32'(dt_ab), 7);
    chk("ab_valid7", 32'(dt_ab_valid), 1);
    chk("viol7", 32'(dt_viol), 0);
    repeat (5) tick(0, 1, 0);
    repeat (3) tick(0, 0, 0);
    tick(1, 0, 0);
    chk("ba_gap3", 32'(dt_ba), 3);
    chk("viol3", 32'(dt_viol), 1);
    chk("sticky3", 32'(viol_sticky), 1);
    tick(1, 0, 1);
    chk("sticky_clr", 32'(viol_sticky), 0);
    tick(1, 0, 0);
    tick(1, 1, 0);
    chk("shoot", 32'(shoot_fault), 1);
    chk("kill_on", 32'(kill), 1);
    tick(1, 0, 1);
    chk("fault_hold", 32'(shoot_fault), 1);
    tick(0, 0, 1);
    chk("fault_exit", 32'(kill), 0);
    chk("ab_kept", 32'(dt_ab), 7);
    logic_B = 1'b1;
    repeat (3) tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("inv_gap4", 32'(dt_ab), 4);
    chk("inv_nofault", 32'(shoot_fault), 0);
    tick(0, 0, 0);
    logic_B = 1'b0;
    tick(1, 0, 0);
    repeat (20) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("sat15", 32'(dt_ab), 15);
    dtime_min = 4'd1;
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    chk("swap0", 32'(dt_ab), 0);
    chk("swap_viol", 32'(dt_viol), 1);
    tick(0, 0, 1);
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    #3 reset = 1'b1;
    #1 model_reset();
    check_all();
    #2 reset = 1'b0;
    tick(0, 1, 0);
    chk("no_meas_after_rst", 32'(dt_ab_valid), 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (2) tick(0, 0, 0);
    tick(0, 1, 0);
    en = 1'b0;
    tick(0, 0, 0);
    chk("en0_keep", 32'(dt_ab), 2);
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, 99));
        lv = r < 50 ? 0 : r < 73 ? 1 : r < 96 ? 2 : 3;
      end
      if ($urandom_range(0, 49) == 0) dtime_min = W'($urandom_range(0, MAXG));
      if ($urandom_range(0, 79) == 0) logic_A = ~logic_A;
      if ($urandom_range(0, 79) == 0) logic_B = ~logic_B;
      en = $urandom_range(0, 99) != 0;
      tick(lv[0], lv[1], $urandom_range(0, 15) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/deadtime_monitor.md
Name: deadtime_monitor

Overview:
- Observes one complementary gate pair (leg A / leg B) downstream of the per-leg dead-time inserters.
- Measures the actual dead time of each commutation A->B and B->A in clk cycles.
- Flags gaps shorter than the programmed minimum and latches a shoot-through fault when both gates are on at once.
- Drives a kill line that the PWM top-level ANDs into both gate outputs. This is the checking end of the dead-time path.

Parameters:
- DTCOUNT_WIDTH, 10, width of the dead-time minimum, gap counter and measurement registers. Matches the `DTCOUNT_WIDTH` macro in PKG_pwm.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  monitor enable, synchronous.
- gate_A  in  1  leg A gate as driven to the pin, synchronous to clk.
- gate_B  in  1  leg B gate as driven to the pin, synchronous to clk.
- logic_A  in  _logic_pwm  polarity of gate_A; 1 = inverted.
- logic_B  in  _logic_pwm  polarity of gate_B; 1 = inverted.
- dtime_min  in  DTCOUNT_WIDTH  minimum allowed gap in cycles.
- fault_clear  in  1  level request to leave the fault state.
- dt_ab  out  DTCOUNT_WIDTH  last measured A-off to B-on gap.
- dt_ba  out  DTCOUNT_WIDTH  last measured B-off to A-on gap.
- dt_ab_valid  out  1  one-cycle pulse when dt_ab updates.
- dt_ba_valid  out  1  one-cycle pulse when dt_ba updates.
- dt_viol  out  1  one-cycle pulse when a measured gap < dtime_min.
- viol_sticky  out  1  set by dt_viol; cleared only by fault_clear or en=0.
- shoot_fault  out  1  high while in S_FAULT.
- kill  out  1  registered; equals shoot_fault.

Behaviour:
- Normalisation: a = gate_A ^ logic_A and b = gate_B ^ logic_B, sampled each posedge. There is no input synchroniser.
- FSM states: S_BOTH_OFF, S_A_ON, S_B_ON, S_FAULT.
- Auxiliary registers:
  - last_leg in {LAST_NONE, LAST_A, LAST_B}.
  - gap_cnt, saturating at 2^DTCOUNT_WIDTH-1; wrap-around is forbidden.
- Reset (async) and en=0 (sync) both force:
  - state S_BOTH_OFF, last_leg LAST_NONE, gap_cnt 0.
  - All pulse outputs 0; viol_sticky, shoot_fault and kill 0.
  - dt_ab and dt_ba are cleared to 0 by reset only; en=0 retains them.
- Any state except S_FAULT with a=1 and b=1 sampled: next state S_FAULT; shoot_fault and kill are high from the following cycle. This rule has priority over every other transition.
- S_BOTH_OFF:
  - a=0, b=0: gap_cnt increments (saturating).
  - a=1 only: go to S_A_ON. If last_leg==LAST_B, then dt_ba <= gap_cnt and dt_ba_valid pulses.
  - b=1 only: go to S_B_ON. If last_leg==LAST_A, then dt_ab <= gap_cnt and dt_ab_valid pulses.
  - Same-leg re-on (last_leg equals the rising leg) and LAST_NONE produce no measurement.
- S_A_ON:
  - a=1, b=0: stay.
  - a=0, b=0: go to S_BOTH_OFF with gap_cnt <= 1 and last_leg <= LAST_A.
  - a=0, b=1 (same-sample commutation): go to S_B_ON, dt_ab <= 0, dt_ab_valid pulses.
- S_B_ON: mirror of S_A_ON.
- Violation check: on any measurement pulse, if the stored value < dtime_min, dt_viol pulses in the same cycle as the valid pulse and viol_sticky is set.
  - dtime_min = 0 disables violations.
  - Comparison is unsigned.
- Measurement latency: valid pulse and registers update one cycle after the sample that shows the rising leg.
- Measured value = number of sampled cycles with both gates low.
- S_FAULT:
  - Hold kill=1.
  - Leave only when fault_clear=1 and a=0 and b=0 are sampled in the same cycle. Then go to S_BOTH_OFF, last_leg LAST_NONE, gap_cnt 0, viol_sticky 0.
  - fault_clear while a gate is still high is ignored, and the block stays in S_FAULT.
- fault_clear outside S_FAULT clears viol_sticky only.
- dtime_min may change at any time and takes effect on the next measurement.

Decomposition:
- PKG_pwm gains:
  - _state_dtmon enum {S_BOTH_OFF, S_A_ON, S_B_ON, S_FAULT}, logic [1:0].
  - _last_leg enum {LAST_NONE, LAST_A, LAST_B}, logic [1:0].
- `DTCOUNT_WIDTH` and _logic_pwm are reused from PKG_pwm.
- Single module with no sub-module. One always_comb next-state block plus one async-reset always_ff.

Test Plan:
- dtime_min=5, logic_A=logic_B=0. A high 10 cycles, both low 7 cycles, B high -> dt_ab=7 and one dt_ab_valid pulse; dt_viol=0.
- Same stimulus but a 3-cycle gap B->A -> dt_ba=3, dt_ba_valid and dt_viol pulse together, viol_sticky=1. A later fault_clear pulse -> viol_sticky=0.
- A high, then B rises while A stays high -> shoot_fault=kill=1 on the next cycle.
  - fault_clear=1 with A still high -> remain faulted.
  - A drops with fault_clear=1 -> shoot_fault=0 next cycle; dt_ab/dt_ba unchanged.
- logic_B=1 (gate_B idles high), A commutates to B with gate_B low after 4 low cycles -> dt_ab=4; no fault from the raw gate_B=1 idle level.
- DTCOUNT_WIDTH=4, gap of 20 cycles -> dt_ab=15 (saturated, no wrap).
  - Same-sample swap A->B -> dt_ab=0 and dt_viol=1 with dtime_min=1.
- Async reset asserted mid-gap (gap_cnt=3) -> all outputs 0 immediately.
  - After release, the first B-on produces no measurement (last_leg LAST_NONE).
